// File: rtl/regfile_sb.sv
// Multi-read-port register file with write bypass and a per-register
// pending-write scoreboard used by decode for hazard stalls.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_rd,
  input  logic                         flush,
  output logic                         any_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic                  wr_en;

  assign wr_en = wen && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_en) begin
      rf_q[waddr] <= wdata;
    end
  end

  // Issue is applied after writeback so a new producer stays pending.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wen) begin
        busy_d[waddr] = 1'b0;
      end
      if (iss_valid) begin
        busy_d[iss_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign any_busy = |busy_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;

    assign ra  = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit = wr_en && (waddr == ra);

    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] =
      hit ? wdata : rf_q[ra];
    assign rbusy[p] = busy_q[ra] && !hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic             flush;
  logic             any_busy;

  typedef struct packed {
    int          id;
    logic [1:0]  kind;
    logic [1:0]  port;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   nid   = 0;

  regfile_sb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_RD(NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raddr(raddr),
    .rdata(rdata),
    .rbusy(rbusy),
    .wen(wen),
    .waddr(waddr),
    .wdata(wdata),
    .iss_valid(iss_valid),
    .iss_rd(iss_rd),
    .flush(flush),
    .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  // kind: 0 = rdata[port], 1 = rbusy[port], 2 = any_busy
  task automatic push(input int k, input int p, input logic [31:0] v);
    exp_t e;
    e.id   = nid;
    e.kind = k[1:0];
    e.port = p[1:0];
    e.val  = v;
    nid++;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen       = 1'b0;
    waddr     = '0;
    wdata     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    flush     = 1'b0;
  endtask

  task automatic rd(input int a0, input int a1, input int a2);
    raddr = {a2[AW-1:0], a1[AW-1:0], a0[AW-1:0]};
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wen   = 1'b1;
    waddr = a[AW-1:0];
    wdata = d;
  endtask

  task automatic iss(input int a);
    iss_valid = 1'b1;
    iss_rd    = a[AW-1:0];
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          2'd0:    act = rdata[e.port*DW +: DW];
          2'd1:    act = {31'd0, rbusy[e.port]};
          default: act = {31'd0, any_busy};
        endcase
        total++;
        if (act !== e.val) begin
          bad++;
          $display("FAIL chk%0d kind=%0d port=%0d got=%h want=%h",
                   e.id, e.kind, e.port, act, e.val);
        end
      end
    end
  end

  initial begin : stim
    idle();
    rd(0, 0, 0);
    rst = 1'b1;
    for (int p = 0; p < NR; p++) begin
      push(0, p, 32'h0);
      push(1, p, 32'h0);
    end
    push(2, 0, 32'h0);
    step();
    rst = 1'b0;

    // reset clears storage and scoreboard
    step();
    rd(5, 6, 0);
    wr(5, 32'hDEADBEEF);
    iss(6);
    push(0, 0, 32'hDEADBEEF);
    step();
    idle();
    push(0, 0, 32'hDEADBEEF);
    push(1, 1, 32'h1);
    push(2, 0, 32'h1);
    step();
    rst = 1'b1;
    wr(5, 32'h00001111);
    iss(6);
    push(0, 0, 32'h00001111);
    push(1, 1, 32'h0);
    push(2, 0, 32'h0);
    step();
    rst = 1'b0;
    idle();
    push(0, 0, 32'h0);
    push(1, 1, 32'h0);
    push(2, 0, 32'h0);

    // bypass on all ports, x0 write ignored
    step();
    rd(7, 7, 7);
    wr(7, 32'h12345678);
    for (int p = 0; p < NR; p++) push(0, p, 32'h12345678);
    step();
    idle();
    for (int p = 0; p < NR; p++) push(0, p, 32'h12345678);
    step();
    rd(0, 0, 0);
    wr(0, 32'hFFFFFFFF);
    for (int p = 0; p < NR; p++) push(0, p, 32'h0);
    step();
    idle();
    push(0, 0, 32'h0);

    // scoreboard lifecycle
    step();
    rd(3, 0, 0);
    iss(3);
    push(1, 0, 32'h0);
    push(2, 0, 32'h0);
    step();
    idle();
    push(1, 0, 32'h1);
    push(2, 0, 32'h1);
    step();
    wr(3, 32'h000000A5);
    push(1, 0, 32'h0);
    push(0, 0, 32'h000000A5);
    push(2, 0, 32'h1);
    step();
    idle();
    push(1, 0, 32'h0);
    push(2, 0, 32'h0);
    push(0, 0, 32'h000000A5);

    // issue and writeback to the same register
    step();
    rd(0, 9, 0);
    iss(9);
    step();
    idle();
    push(1, 1, 32'h1);
    step();
    iss(9);
    wr(9, 32'h00000099);
    push(0, 1, 32'h00000099);
    push(1, 1, 32'h0);
    step();
    idle();
    push(1, 1, 32'h1);
    push(0, 1, 32'h00000099);
    push(2, 0, 32'h1);
    step();
    wr(9, 32'h00000099);
    step();
    idle();
    push(2, 0, 32'h0);

    // flush drops pending marks and same-cycle issue, keeps write
    step();
    iss(1);
    step();
    iss(2);
    step();
    iss(31);
    step();
    idle();
    rd(1, 2, 31);
    flush = 1'b1;
    iss(4);
    wr(2, 32'h00000055);
    push(0, 1, 32'h00000055);
    push(1, 0, 32'h1);
    push(1, 1, 32'h0);
    push(1, 2, 32'h1);
    push(2, 0, 32'h1);
    step();
    idle();
    rd(1, 2, 4);
    for (int p = 0; p < NR; p++) push(1, p, 32'h0);
    push(2, 0, 32'h0);
    push(0, 1, 32'h00000055);

    // x0 never marked busy
    step();
    rd(0, 0, 0);
    iss(0);
    push(1, 0, 32'h0);
    push(2, 0, 32'h0);
    step();
    idle();
    push(1, 0, 32'h0);
    push(2, 0, 32'h0);

    step();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
